sys_ram: RTL and testbench
==========================

SYS_RAM -- requirements
Module: sys_ram

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two, 4..4096.
REQ-002 Parameter BASE_ADDR, default 64'h0: byte address of word 0.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 address  input  64  byte address from the DMA-side initiator.
REQ-006 data_in  input  32  write data, sampled when write=1.
REQ-007 write  input  1  write request, level-sampled each rising edge.
REQ-008 read  input  1  read request, level-sampled each rising edge.
REQ-009 data_out  output  32  registered read data.
REQ-010 read_valid  output  1  one-cycle pulse qualifying data_out.
REQ-011 err  output  1  one-cycle pulse flagging a rejected access.
REQ-012 mode  output  2  registered FSM state: 0 IDLE, 1 WRITE, 2 READ.
REQ-013 wr_count, rd_count  output  16 each  saturating counts of accepted writes and accepted reads.

Function
REQ-014 Word index SHALL be (address-BASE_ADDR)>>2, computed at full 64-bit width.
REQ-015 An access SHALL be rejected if address[1:0]!=0, address<BASE_ADDR, or the word index is >= DEPTH_WORDS.
- A rejected write SHALL leave the array unchanged.
- A rejected read SHALL produce no read_valid.
- Either rejection SHALL pulse err in the following cycle.
REQ-016 Accepted write: the array word SHALL update at the sampling edge; wr_count SHALL increment.
REQ-017 Accepted read: data_out SHALL present the addressed word, with read_valid=1, exactly one cycle after the sampling edge; rd_count SHALL increment.
REQ-018 data_out SHALL hold its last value while read_valid=0.
REQ-019 write=1 and read=1 on the same edge:
- the write SHALL be performed if legal;
- the read SHALL be dropped;
- err SHALL pulse.
REQ-020 Read of a word written on the immediately preceding edge SHALL return the new data.
REQ-021 FSM transitions:
- IDLE->WRITE on an accepted write; IDLE->READ on an accepted read.
- WRITE->READ on an accepted read with write=0.
- READ->WRITE on an accepted write.
- Any state->IDLE on an edge with write=0 and read=0.
- Rejected-only edges SHALL keep the current state.
REQ-022 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-023 err and read_valid SHALL never both be 1 for the same access.

Reset
REQ-024 RESET=1 SHALL immediately force data_out=0, read_valid=0, err=0, mode=IDLE, wr_count=0, rd_count=0, independent of CLK.
REQ-025 Array contents SHALL NOT be cleared by reset; a read issued before reset that has not yet produced read_valid SHALL be discarded.
REQ-026 The first access SHALL be sampled on the first rising edge after RESET deasserts.

Structure
REQ-027 Mode encodings and the 64-bit address width constant SHALL live in a shared ADMA package used by the DMA engine and this block.
REQ-028 Address decode (alignment, range, index) SHALL be one combinational sub-module, sys_ram_decode; array, FSM and counters stay in sys_ram.

Verification
REQ-029 Write data 4,8,...,96 to addresses 4,8,...,96, then read the same addresses -> each read_valid one cycle after request with matching data; wr_count=24, rd_count=24.
REQ-030 Write 32'hDEADBEEF to 512, then read 512 on the next edge -> data_out=32'hDEADBEEF, mode sequence WRITE->READ->IDLE.
REQ-031 Read at address 6, then at address 4*DEPTH_WORDS -> err pulses twice, no read_valid, rd_count unchanged.
REQ-032 write=1 and read=1 at address 8 with data 32'h55 -> word 8 becomes 32'h55, err=1, read_valid=0.
REQ-033 Assert RESET mid read burst -> outputs zero asynchronously; pending read_valid suppressed; prior written data still readable afterwards.
REQ-034 Force 65540 accepted writes -> wr_count holds 16'hFFFF.

Source files
------------

// File: rtl/adma_pkg.sv
// Shared ADMA definitions: bus widths, RAM mode encoding and the access payload
// seen by memory-mapped targets of the DMA engine.
package adma_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_WRITE = 2'd1,
        MODE_READ  = 2'd2
    } mode_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wr;
        logic              rd;
    } ram_req_t;

    // Saturating increment: sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sys_ram_decode.sv
// Byte-address decode for sys_ram: alignment, window range and word index.
module sys_ram_decode
    import adma_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h0
) (
    input  logic [ADDR_W-1:0]              i_address,
    output logic                           o_legal_c,
    output logic [$clog2(DEPTH_WORDS)-1:0] o_index_c
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [ADDR_W-1:0] w_offset;
    logic [ADDR_W-1:0] w_word;
    logic              w_misaligned;
    logic              w_below;
    logic              w_over;

    // Index math stays at full address width so high bits can never alias into range
    always_comb begin
        w_offset     = i_address - BASE_ADDR;
        w_word       = w_offset >> 2;
        w_misaligned = |i_address[1:0];
        w_below      = i_address < BASE_ADDR;
        w_over       = w_word >= ADDR_W'(DEPTH_WORDS);
        o_legal_c    = !(w_misaligned || w_below || w_over);
        o_index_c    = w_word[IDX_W-1:0];
    end

endmodule

// File: rtl/sys_ram.sv
// Single-port word RAM on the DMA side: registered reads, error pulses on rejected
// accesses, a mode FSM and saturating access counters.
module sys_ram
    import adma_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write,
    input  logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic              read_valid,
    output logic              err,
    output logic [1:0]        mode,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    ram_req_t          w_req;
    logic              w_legal;
    logic [IDX_W-1:0]  w_index;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_any;
    logic              w_err_nxt;
    logic              w_rv_nxt;

    mode_e             r_state;
    mode_e             w_state_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_data_out;
    logic              r_read_valid;
    logic              r_err;
    logic [CNT_W-1:0]  r_wr_count;
    logic [CNT_W-1:0]  r_rd_count;

    assign w_req = '{addr: address, data: data_in, wr: write, rd: read};

    sys_ram_decode #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_decode (
        .i_address (w_req.addr),
        .o_legal_c (w_legal),
        .o_index_c (w_index)
    );

    // A simultaneous read is always dropped in favour of the write
    assign w_wr_ok = w_req.wr && w_legal;
    assign w_rd_ok = w_req.rd && !w_req.wr && w_legal;
    assign w_any   = w_req.wr || w_req.rd;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= MODE_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Rejected-only edges fall through and keep the current state
    always_comb begin
        w_state_nxt = r_state;
        if (!w_any) begin
            w_state_nxt = MODE_IDLE;
        end else if (w_wr_ok) begin
            w_state_nxt = MODE_WRITE;
        end else if (w_rd_ok) begin
            w_state_nxt = MODE_READ;
        end
    end

    always_comb begin
        w_rv_nxt  = w_rd_ok;
        w_err_nxt = w_any && (!w_legal || (w_req.wr && w_req.rd));
    end

    // Array is deliberately outside reset so contents survive it
    always_ff @(posedge CLK) begin
        if (w_wr_ok) begin
            r_mem[w_index] <= w_req.data;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_data_out   <= '0;
            r_read_valid <= 1'b0;
            r_err        <= 1'b0;
            r_wr_count   <= '0;
            r_rd_count   <= '0;
        end else begin
            r_read_valid <= w_rv_nxt;
            r_err        <= w_err_nxt;
            if (w_rv_nxt) begin
                r_data_out <= r_mem[w_index];
                r_rd_count <= sat_inc(r_rd_count);
            end
            if (w_wr_ok) begin
                r_wr_count <= sat_inc(r_wr_count);
            end
        end
    end

    assign data_out   = r_data_out;
    assign read_valid = r_read_valid;
    assign err        = r_err;
    assign mode       = r_state;
    assign wr_count   = r_wr_count;
    assign rd_count   = r_rd_count;

endmodule

// File: tb/tb_sys_ram.sv
// Self-checking bench for sys_ram against a word-array reference model.
module tb_sys_ram;
    import adma_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam logic [63:0] BASE  = 64'h0;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [63:0] address;
    logic [31:0] data_in;
    logic        write;
    logic        read;
    logic [31:0] data_out;
    logic        read_valid;
    logic        err;
    logic [1:0]  mode;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] e_dout;
    logic        e_rv;
    logic        e_err;
    int          e_mode;
    int          e_wr;
    int          e_rd;

    always #5 CLK = ~CLK;

    sys_ram #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .address    (address),
        .data_in    (data_in),
        .write      (write),
        .read       (read),
        .data_out   (data_out),
        .read_valid (read_valid),
        .err        (err),
        .mode       (mode),
        .wr_count   (wr_count),
        .rd_count   (rd_count)
    );

    function automatic bit addr_ok(input logic [63:0] a);
        if (a % 64'd4 != 64'd0) return 1'b0;
        if (a < BASE) return 1'b0;
        return ((a - BASE) / 64'd4) < 64'(DEPTH);
    endfunction

    task automatic model_reset();
        e_dout = '0; e_rv = 1'b0; e_err = 1'b0; e_mode = 0; e_wr = 0; e_rd = 0;
    endtask

    // One sampling edge: drive on the falling edge, update the model at the rising edge, settle
    task automatic step(input logic w, input logic r, input logic [63:0] a, input logic [31:0] d);
        bit ok;
        int idx;
        @(negedge CLK);
        write = w; read = r; address = a; data_in = d;
        @(posedge CLK);
        ok  = addr_ok(a);
        idx = ok ? int'((a - BASE) / 64'd4) : 0;
        e_err = (w || r) && (!ok || (w && r));
        e_rv  = r && !w && ok;
        if (e_rv) begin
            e_dout = m_mem[idx];
            if (e_rd < 65535) e_rd++;
        end
        if (w && ok) begin
            m_mem[idx] = d;
            if (e_wr < 65535) e_wr++;
        end
        if (!w && !r)       e_mode = 0;
        else if (w && ok)   e_mode = 1;
        else if (e_rv)      e_mode = 2;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        write = 1'b0; read = 1'b0;
        #2 RESET = 1'b1;
        #1;
        model_reset();
        vectors++;
        if ({data_out, read_valid, err, mode, wr_count, rd_count} !== 84'd0) begin
            miscompares++;
            $display("FAIL async_reset: got dout=%h rv=%b err=%b mode=%0d wr=%0d rd=%0d, want all zero",
                     data_out, read_valid, err, mode, wr_count, rd_count);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; write = 1'b0; read = 1'b0; address = '0; data_in = '0;
        #2;
        model_reset();
        vectors++;
        if ({data_out, read_valid, err, mode, wr_count, rd_count} !== 84'd0) begin
            miscompares++;
            $display("FAIL power_on_reset: got dout=%h rv=%b err=%b mode=%0d wr=%0d rd=%0d, want all zero",
                     data_out, read_valid, err, mode, wr_count, rd_count);
        end
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(1'b1, 1'b0, 64'(i * 4), $urandom);
            vectors++;
            if (err !== 1'b0 || mode !== 2'd1 || wr_count !== 16'(e_wr)) begin
                miscompares++;
                $display("FAIL fill[%0d]: got err=%b mode=%0d wr=%0d, want err=0 mode=1 wr=%0d",
                         i, err, mode, wr_count, e_wr);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 64'($urandom_range(0, DEPTH - 1) * 4) + 64'($urandom_range(1, 3));
                1:       a = 64'(DEPTH * 4) + 64'($urandom_range(0, 63) * 4);
                2:       a = {$urandom, $urandom} & ~64'h3;
                default: a = 64'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            step(1'($urandom), 1'($urandom), a, $urandom);
            vectors++;
            if ({data_out, read_valid, err, mode, wr_count, rd_count} !==
                {e_dout, e_rv, e_err, 2'(e_mode), 16'(e_wr), 16'(e_rd)}) begin
                miscompares++;
                $display("FAIL random[%0d] a=%h w=%b r=%b: got dout=%h rv=%b err=%b mode=%0d wr=%0d rd=%0d, want dout=%h rv=%b err=%b mode=%0d wr=%0d rd=%0d",
                         i, a, write, read, data_out, read_valid, err, mode, wr_count, rd_count,
                         e_dout, e_rv, e_err, e_mode, e_wr, e_rd);
            end
            vectors++;
            if (read_valid === 1'b1 && err === 1'b1) begin
                miscompares++;
                $display("FAIL rv_err_exclusive[%0d]: got rv=1 err=1, want not both", i);
            end
        end
    endtask

    task automatic test_errors();
        int rd0;
        step(1'b0, 1'b0, '0, '0);
        rd0 = e_rd;
        step(1'b0, 1'b1, 64'd6, '0);
        vectors++;
        if (err !== 1'b1 || read_valid !== 1'b0 || mode !== 2'd0) begin
            miscompares++;
            $display("FAIL misaligned_read: got err=%b rv=%b mode=%0d, want err=1 rv=0 mode=0", err, read_valid, mode);
        end
        step(1'b0, 1'b1, 64'(4 * DEPTH), '0);
        vectors++;
        if (err !== 1'b1 || read_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL range_read: got err=%b rv=%b, want err=1 rv=0", err, read_valid);
        end
        vectors++;
        if (rd_count !== 16'(rd0)) begin
            miscompares++;
            $display("FAIL rejected_rd_count: got %0d, want %0d", rd_count, rd0);
        end
        step(1'b1, 1'b0, 64'(4 * DEPTH - 2), 32'hFFFF_FFFF);
        vectors++;
        if (err !== 1'b1 || wr_count !== 16'(e_wr)) begin
            miscompares++;
            $display("FAIL rejected_write: got err=%b wr=%0d, want err=1 wr=%0d", err, wr_count, e_wr);
        end
        step(1'b0, 1'b0, '0, '0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_one_cycle: got err=%b, want 0", err);
        end
    endtask

    task automatic test_both();
        step(1'b1, 1'b1, 64'd8, 32'h55);
        vectors++;
        if (err !== 1'b1 || read_valid !== 1'b0 || mode !== 2'd1) begin
            miscompares++;
            $display("FAIL write_read_same_edge: got err=%b rv=%b mode=%0d, want err=1 rv=0 mode=1", err, read_valid, mode);
        end
        step(1'b0, 1'b1, 64'd8, '0);
        vectors++;
        if (data_out !== 32'h55 || read_valid !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL collided_write_data: got dout=%h rv=%b err=%b, want dout=00000055 rv=1 err=0", data_out, read_valid, err);
        end
    endtask

    task automatic test_write_then_read();
        step(1'b1, 1'b0, 64'd512, 32'hDEADBEEF);
        vectors++;
        if (mode !== 2'd1) begin
            miscompares++;
            $display("FAIL wr512_mode: got %0d, want 1", mode);
        end
        step(1'b0, 1'b1, 64'd512, '0);
        vectors++;
        if (data_out !== 32'hDEADBEEF || read_valid !== 1'b1 || mode !== 2'd2) begin
            miscompares++;
            $display("FAIL rd512: got dout=%h rv=%b mode=%0d, want dout=deadbeef rv=1 mode=2", data_out, read_valid, mode);
        end
        step(1'b0, 1'b0, '0, '0);
        vectors++;
        if (mode !== 2'd0 || read_valid !== 1'b0 || data_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL idle_hold: got mode=%0d rv=%b dout=%h, want mode=0 rv=0 dout=deadbeef", mode, read_valid, data_out);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 1'b0, 64'(4 * k), 32'(4 * k));
            vectors++;
            if (err !== 1'b0 || mode !== 2'd1) begin
                miscompares++;
                $display("FAIL seq_write[%0d]: got err=%b mode=%0d, want err=0 mode=1", k, err, mode);
            end
        end
        for (int k = 1; k <= 24; k++) begin
            step(1'b0, 1'b1, 64'(4 * k), '0);
            vectors++;
            if (read_valid !== 1'b1 || data_out !== 32'(4 * k)) begin
                miscompares++;
                $display("FAIL seq_read[%0d]: got rv=%b dout=%h, want rv=1 dout=%h", k, read_valid, data_out, 32'(4 * k));
            end
        end
        vectors++;
        if (wr_count !== 16'd24 || rd_count !== 16'd24) begin
            miscompares++;
            $display("FAIL seq_counts: got wr=%0d rd=%0d, want wr=24 rd=24", wr_count, rd_count);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 64'd16, '0);
        vectors++;
        if (read_valid !== 1'b1 || data_out !== e_dout) begin
            miscompares++;
            $display("FAIL burst_read: got rv=%b dout=%h, want rv=1 dout=%h", read_valid, data_out, e_dout);
        end
        #1 RESET = 1'b1;
        #1;
        model_reset();
        vectors++;
        if ({data_out, read_valid, err, mode, wr_count, rd_count} !== 84'd0) begin
            miscompares++;
            $display("FAIL midcycle_reset: got dout=%h rv=%b err=%b mode=%0d wr=%0d rd=%0d, want all zero",
                     data_out, read_valid, err, mode, wr_count, rd_count);
        end
        @(negedge CLK);
        RESET = 1'b0;
        read = 1'b1; address = 64'd20;
        #3 RESET = 1'b1;
        @(posedge CLK);
        #1;
        vectors++;
        if (read_valid !== 1'b0 || rd_count !== 16'd0) begin
            miscompares++;
            $display("FAIL pending_read_discard: got rv=%b rd=%0d, want rv=0 rd=0", read_valid, rd_count);
        end
        @(negedge CLK);
        read = 1'b0;
        RESET = 1'b0;
        step(1'b0, 1'b1, 64'd20, '0);
        vectors++;
        if (read_valid !== 1'b1 || data_out !== e_dout || rd_count !== 16'd1) begin
            miscompares++;
            $display("FAIL post_reset_read: got rv=%b dout=%h rd=%0d, want rv=1 dout=%h rd=1", read_valid, data_out, rd_count, e_dout);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            step(1'b1, 1'b0, 64'((i % int'(DEPTH)) * 4), 32'(i));
            if (i == 65533) begin
                vectors++;
                if (wr_count !== 16'hFFFE) begin
                    miscompares++;
                    $display("FAIL pre_saturate: got wr=%h, want fffe", wr_count);
                end
            end
        end
        vectors++;
        if (wr_count !== 16'hFFFF || rd_count !== 16'd0) begin
            miscompares++;
            $display("FAIL saturate: got wr=%h rd=%h, want wr=ffff rd=0000", wr_count, rd_count);
        end
        step(1'b0, 1'b1, 64'd4, '0);
        vectors++;
        if (data_out !== e_dout || read_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL after_saturate_read: got dout=%h rv=%b, want dout=%h rv=1", data_out, read_valid, e_dout);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_random();
        test_errors();
        test_both();
        test_write_then_read();
        test_sequential();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
